mux_32x2: RTL and testbench



---
 rtl/mux_32x2.sv | 71 +++++++
 tb/tb_mux_32x2.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_32x2.sv
// ---------------------------------------------------------------------------
// mux_32x2
//   Two-input word multiplexer for operand selection on NN simulator datapaths.
//   It provides a zero-latency combinational output and a one-cycle registered
//   copy. The registered copy carries a valid flag and a change strobe.
//
// Ports
//   clk        in   1      system clock, rising edge
//   rst_n      in   1      asynchronous reset, active low
//   in0        in   WIDTH  word chosen when select = 0
//   in1        in   WIDTH  word chosen when select = 1
//   select     in   1      0 -> in0, 1 -> in1
//   in_valid   in   1      qualifies in0/in1/select for the registered path
//   out        out  WIDTH  combinational selected word
//   out_q      out  WIDTH  registered selected word (1-cycle latency)
//   out_valid  out  1      out_q was captured with in_valid = 1
//   out_chg    out  1      1-cycle pulse: out_q took a value different from before
// ---------------------------------------------------------------------------
module mux_32x2 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             select,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic             out_valid,
  output logic             out_chg
);

  logic [WIDTH-1:0] sel_word;
  logic [WIDTH-1:0] word_q, word_d;
  logic             valid_q, valid_d;
  logic             chg_q, chg_d;

  // Plain ternary, not an if/else: an X on select merges the two inputs to X
  // in simulation instead of silently falling back to in0.
  assign sel_word = select ? in1 : in0;
  assign out      = sel_word;

  always_comb begin
    word_d  = word_q;
    valid_d = 1'b0;
    chg_d   = 1'b0;
    if (in_valid) begin
      word_d  = sel_word;
      valid_d = 1'b1;
      chg_d   = (sel_word != word_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q  <= '0;
      valid_q <= 1'b0;
      chg_q   <= 1'b0;
    end else begin
      word_q  <= word_d;
      valid_q <= valid_d;
      chg_q   <= chg_d;
    end
  end

  assign out_q     = word_q;
  assign out_valid = valid_q;
  assign out_chg   = chg_q;

endmodule

// File: tb/tb_mux_32x2.sv
module tb_mux_32x2;

  typedef struct {
    logic [31:0] q;
    logic        v;
    logic        c;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] in0, in1;
  logic        sel;
  logic        in_valid;
  logic [31:0] dout;
  logic [31:0] dout_q;
  logic        dvalid;
  logic        dchg;

  int total = 0;
  int bad   = 0;

  exp_t        exp_q[$];
  exp_t        cur;
  logic [31:0] mdl_q;

  mux_32x2 #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in0      (in0),
    .in1      (in1),
    .select   (sel),
    .in_valid (in_valid),
    .out      (dout),
    .out_q    (dout_q),
    .out_valid(dvalid),
    .out_chg  (dchg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Push the expected registered result for the current inputs, take one
  // clock edge, then pop the entry the DUT should now be showing.
  task automatic advance();
    exp_t        e;
    logic [31:0] w;
    w = sel ? in1 : in0;
    if (in_valid) begin
      e.q = w;
      e.v = 1'b1;
      e.c = (w != mdl_q);
    end else begin
      e.q = mdl_q;
      e.v = 1'b0;
      e.c = 1'b0;
    end
    mdl_q = e.q;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    cur = exp_q.pop_front();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in0 = '0; in1 = '0; sel = 1'b0; in_valid = 1'b0;
    mdl_q = '0;
    #3;
    total++;
    if (dout_q !== 32'h0 || dvalid !== 1'b0 || dchg !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: got q=%h v=%b c=%b want q=0 v=0 c=0", dout_q, dvalid, dchg);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_comb();
    logic [31:0] want[5];
    want[0] = 32'hFFFFFFFF; want[1] = 32'hBBBB0000; want[2] = 32'h01234567;
    want[3] = 32'hABCDEF00; want[4] = 32'hBBBB0000;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: begin in0 = 32'hFFFFFFFF; in1 = 32'h01234567; sel = 1'b0; end
        1: in0 = 32'hBBBB0000;
        2: sel = 1'b1;
        3: in1 = 32'hABCDEF00;
        default: sel = 1'b0;
      endcase
      #1;
      total++;
      if (dout !== want[i]) begin
        bad++;
        $display("FAIL comb_step%0d: got %h want %h", i, dout, want[i]);
      end
    end
  endtask

  task automatic test_capture();
    @(negedge clk);
    in_valid = 1'b1; sel = 1'b1; in1 = 32'hABCDEF00;
    advance();
    total++;
    if (dout_q !== cur.q || dvalid !== cur.v || dchg !== cur.c || cur.q !== 32'hABCDEF00 || cur.c !== 1'b1) begin
      bad++;
      $display("FAIL capture: got q=%h v=%b c=%b want q=%h v=%b c=%b", dout_q, dvalid, dchg, cur.q, cur.v, cur.c);
    end
    in_valid = 1'b0;
    advance();
    total++;
    if (dout_q !== 32'hABCDEF00 || dvalid !== 1'b0 || dchg !== 1'b0) begin
      bad++;
      $display("FAIL capture_hold: got q=%h v=%b c=%b want q=abcdef00 v=0 c=0", dout_q, dvalid, dchg);
    end
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1; sel = 1'b0; in0 = 32'h01234567;
    for (int i = 0; i < 2; i++) begin
      advance();
      total++;
      if (dout_q !== 32'h01234567 || dvalid !== 1'b1 || dchg !== (i == 0) || dchg !== cur.c) begin
        bad++;
        $display("FAIL back_to_back_beat%0d: got q=%h v=%b c=%b want q=01234567 v=1 c=%b", i, dout_q, dvalid, dchg, cur.c);
      end
    end
  endtask

  task automatic test_unselected();
    in_valid = 1'b1; sel = 1'b0; in0 = 32'hBBBB0000;
    advance();
    for (int i = 0; i < 4; i++) begin
      in1 = $urandom();
      in_valid = i[0];
      #1;
      total++;
      if (dout !== 32'hBBBB0000) begin
        bad++;
        $display("FAIL unselected_comb%0d: got %h want bbbb0000", i, dout);
      end
      advance();
      total++;
      if (dout_q !== 32'hBBBB0000 || dchg !== 1'b0 || dvalid !== cur.v) begin
        bad++;
        $display("FAIL unselected_reg%0d: got q=%h v=%b c=%b want q=bbbb0000 v=%b c=0", i, dout_q, dvalid, dchg, cur.v);
      end
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    in_valid = 1'b1; sel = 1'b1; in1 = 32'h55AA55AA;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (dout_q !== 32'h0 || dvalid !== 1'b0 || dchg !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: got q=%h v=%b c=%b want q=0 v=0 c=0", dout_q, dvalid, dchg);
    end
    sel = 1'b0; in0 = 32'h12345678;
    #1;
    total++;
    if (dout !== 32'h12345678) begin
      bad++;
      $display("FAIL comb_in_reset: got %h want 12345678", dout);
    end
    exp_q.delete();
    mdl_q = '0;
    @(negedge clk);
    rst_n = 1'b1;
    in0 = 32'h0;
    advance();
    total++;
    if (dout_q !== 32'h0 || dvalid !== 1'b1 || dchg !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_zero: got q=%h v=%b c=%b want q=0 v=1 c=0", dout_q, dvalid, dchg);
    end
    in0 = 32'h00000001;
    advance();
    total++;
    if (dout_q !== 32'h1 || dvalid !== 1'b1 || dchg !== 1'b1) begin
      bad++;
      $display("FAIL post_reset_nonzero: got q=%h v=%b c=%b want q=1 v=1 c=1", dout_q, dvalid, dchg);
    end
  endtask

  task automatic test_random();
    logic [31:0] w;
    for (int i = 0; i < 1000; i++) begin
      in0 = ($urandom_range(0, 3) == 0) ? mdl_q : $urandom();
      in1 = ($urandom_range(0, 3) == 0) ? in0 : $urandom();
      sel = $urandom_range(0, 1);
      in_valid = ($urandom_range(0, 3) != 0);
      w = sel ? in1 : in0;
      #1;
      total++;
      if (dout !== w) begin
        bad++;
        $display("FAIL rand_comb%0d: got %h want %h", i, dout, w);
      end
      advance();
      total++;
      if (dout_q !== cur.q || dvalid !== cur.v || dchg !== cur.c) begin
        bad++;
        $display("FAIL rand_reg%0d: got q=%h v=%b c=%b want q=%h v=%b c=%b", i, dout_q, dvalid, dchg, cur.q, cur.v, cur.c);
      end
    end
  endtask

  initial begin
    test_reset();
    test_comb();
    test_capture();
    test_back_to_back();
    test_unselected();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
